dmem_responder: RTL and testbench

- Data-memory responder at the far end of the LSU memory-request interface.
- Accepts one load/store request per cycle, carrying the addr/wr_data/MemWrite/MemRead fields plus an ROB tag.
- Performs the access on a word-addressed array and returns one in-order response (rd_data/MemWrite/MemRead, tag, error) after a fixed pipeline latency.
- Credit-based flow control sizes in-flight plus buffered responses to a small output FIFO, so completion-stage backpressure never drops a response.

---
 rtl/dmem_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the LSU request port.
//
// Accepts one load/store per cycle, performs the access on a word-addressed
// array and returns one in-order response per request after LATENCY cycles
// through a first-word-fall-through output FIFO. An outstanding-request credit
// counter (accepted but not yet popped) limits acceptance to QDEPTH, so every
// response leaving the pipeline always finds a free FIFO slot.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_addr, req_wr_data         byte address, store data
//   req_MemWrite, req_MemRead     store / load flags
//   req_robNum                    ROB tag, echoed in the response
//   req_funct3                    RV32 funct3 (only with DMEM_BYTE_EN)
//   resp_valid / resp_ready       response handshake
//   resp_rd_data                  load data (0 for stores, no-ops and errors)
//   resp_MemWrite, resp_MemRead   echoed request flags
//   resp_robNum                   echoed ROB tag
//   resp_err                      misaligned, out of range or both flags set
//
// Build option: define DMEM_BYTE_EN for byte/halfword accesses selected by
// req_funct3; otherwise every access is a full aligned word.
module dmem_responder #(
  parameter int MEM_WORDS     = 1024,
  parameter int LATENCY       = 2,
  parameter int QDEPTH        = 4,
  parameter int ROB_SIZE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wr_data,
  input  logic                     req_MemWrite,
  input  logic                     req_MemRead,
  input  logic [ROB_SIZE_BITS-1:0] req_robNum,
`ifdef DMEM_BYTE_EN
  input  logic [2:0]               req_funct3,
`endif
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rd_data,
  output logic                     resp_MemWrite,
  output logic                     resp_MemRead,
  output logic [ROB_SIZE_BITS-1:0] resp_robNum,
  output logic                     resp_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [31:0]              word;
    logic                     mw;
    logic                     mr;
    logic [ROB_SIZE_BITS-1:0] tag;
    logic                     err;
`ifdef DMEM_BYTE_EN
    logic [1:0]               lane;
    logic [2:0]               f3;
`endif
  } stage_t;

  typedef struct packed {
    logic [31:0]              rd_data;
    logic                     mw;
    logic                     mr;
    logic [ROB_SIZE_BITS-1:0] tag;
    logic                     err;
  } resp_t;

  logic [31:0]   mem [MEM_WORDS];
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          pop;
  logic          acc_vld;
  stage_t        acc_dat;
  logic          push_vld;
  stage_t        push_dat;
  logic [AW-1:0] idx;
  logic          bad;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;
  resp_t         fifo_mem [QDEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  resp_t         head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef DMEM_BYTE_EN
  function automatic logic f3_bad(input logic mw, input logic mr, input logic [2:0] f3);
    logic ld_ok;
    logic st_ok;
    ld_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (f3 == 3'b100) || (f3 == 3'b101);
    st_ok = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    return (mr & ~ld_ok) | (mw & ~st_ok);
  endfunction

  function automatic logic misaligned(input logic [1:0] lo, input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lo, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction
`endif

  // Loads return data only when the access was legal; everything else reads 0.
  function automatic resp_t fmt(input stage_t s);
    resp_t r;
    r.mw      = s.mw;
    r.mr      = s.mr;
    r.tag     = s.tag;
    r.err     = s.err;
    r.rd_data = 32'd0;
    if (s.mr && !s.err) begin
`ifdef DMEM_BYTE_EN
      r.rd_data = load_extend(s.word, s.lane, s.f3);
`else
      r.rd_data = s.word;
`endif
    end
    return r;
  endfunction

  assign req_ready  = outstanding < CW'(QDEPTH);
  assign accept     = req_valid & req_ready;
  assign resp_valid = count != '0;
  assign pop        = resp_valid & resp_ready;

  // Access stage: decode, error check, array read (combinational, so a load
  // sees a store accepted on the previous edge).
  always_comb begin
    idx = req_addr[AW+1:2];
    bad = ((req_addr >> (AW + 2)) != 32'd0) | (req_MemWrite & req_MemRead);
`ifdef DMEM_BYTE_EN
    bad     = bad | f3_bad(req_MemWrite, req_MemRead, req_funct3) |
              misaligned(req_addr[1:0], req_funct3);
    wr_be   = store_be(req_addr[1:0], req_funct3);
    wr_word = req_wr_data << {req_addr[1:0], 3'b000};
`else
    bad     = bad | (req_addr[1:0] != 2'b00);
    wr_be   = 4'b1111;
    wr_word = req_wr_data;
`endif
    acc_vld      = accept;
    acc_dat.word = mem[idx];
    acc_dat.mw   = req_MemWrite;
    acc_dat.mr   = req_MemRead;
    acc_dat.tag  = req_robNum;
    acc_dat.err  = bad;
`ifdef DMEM_BYTE_EN
    acc_dat.lane = req_addr[1:0];
    acc_dat.f3   = req_funct3;
`endif
  end

  // Stores commit on the accepting edge; a reset cycle has no memory side effect.
  always_ff @(posedge clk) begin
    if (accept && !rst && req_MemWrite && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // Delay line: LATENCY-1 register stages; the FIFO write is the final stage.
  if (LATENCY == 1) begin : g_direct
    assign push_vld = acc_vld;
    assign push_dat = acc_dat;
  end else begin : g_pipe
    stage_t dat_p [LATENCY-1];
    logic   vld_p [LATENCY-1];

    // ---- access -> delay stages ----
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < LATENCY - 1; k++) vld_p[k] <= 1'b0;
      end else begin
        vld_p[0] <= acc_vld;
        for (int k = 1; k < LATENCY - 1; k++) vld_p[k] <= vld_p[k-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_p[0] <= acc_dat;
      for (int k = 1; k < LATENCY - 1; k++) dat_p[k] <= dat_p[k-1];
    end

    assign push_vld = vld_p[LATENCY-2];
    assign push_dat = dat_p[LATENCY-2];
  end

  // ---- delay stages -> output FIFO ----
  always_ff @(posedge clk) begin
    if (push_vld) fifo_mem[wptr] <= fmt(push_dat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (push_vld) wptr <= ptr_next(wptr);
      if (pop)      rptr <= ptr_next(rptr);
      case ({push_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry is masked when the FIFO is empty so stale storage never shows.
  assign head          = fifo_mem[rptr];
  assign resp_rd_data  = resp_valid ? head.rd_data : 32'd0;
  assign resp_MemWrite = resp_valid & head.mw;
  assign resp_MemRead  = resp_valid & head.mr;
  assign resp_robNum   = resp_valid ? head.tag : '0;
  assign resp_err      = resp_valid & head.err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [31:0]   req_wr_data;
  logic          req_MemWrite;
  logic          req_MemRead;
  logic [RB-1:0] req_robNum;
`ifdef DMEM_BYTE_EN
  logic [2:0]    req_funct3;
`endif
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rd_data;
  logic          resp_MemWrite;
  logic          resp_MemRead;
  logic [RB-1:0] resp_robNum;
  logic          resp_err;

  typedef struct packed {
    logic [31:0]   rd;
    logic          mw;
    logic          mr;
    logic [RB-1:0] tag;
    logic          err;
  } rsp_t;

  rsp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(2), .QDEPTH(4), .ROB_SIZE_BITS(RB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .req_MemWrite (req_MemWrite),
    .req_MemRead  (req_MemRead),
    .req_robNum   (req_robNum),
`ifdef DMEM_BYTE_EN
    .req_funct3   (req_funct3),
`endif
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_data (resp_rd_data),
    .resp_MemWrite(resp_MemWrite),
    .resp_MemRead (resp_MemRead),
    .resp_robNum  (resp_robNum),
    .resp_err     (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic w, input logic r,
                            input logic [RB-1:0] tag, input logic err);
    rsp_t e;
    e.rd  = rd;
    e.mw  = w;
    e.mr  = r;
    e.tag = tag;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Present one request for one cycle; called just after a rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic r, input logic [RB-1:0] tag,
                       input logic [31:0] exp_rd, input logic exp_err);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wr_data  = d;
    req_MemWrite = w;
    req_MemRead  = r;
    req_robNum   = tag;
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    if (req_ready) expect_rsp(exp_rd, w, r, tag, exp_err);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: every popped response is compared against the scoreboard head.
  always @(negedge clk) begin
    rsp_t got;
    rsp_t want;
    if (!rst && resp_valid && resp_ready) begin
      got = {resp_rd_data, resp_MemWrite, resp_MemRead, resp_robNum, resp_err};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL stale_resp: got tag %0d rd 0x%h, expected no response", resp_robNum,
                 resp_rd_data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL resp_tag%0d: got rd=0x%h mw=%b mr=%b tag=%0d err=%b, expected rd=0x%h mw=%b mr=%b tag=%0d err=%b",
                   want.tag, got.rd, got.mw, got.mr, got.tag, got.err,
                   want.rd, want.mw, want.mr, want.tag, want.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int waited;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_wr_data  = '0;
    req_MemWrite = 1'b0;
    req_MemRead  = 1'b0;
    req_robNum   = '0;
    resp_ready   = 1'b1;
`ifdef DMEM_BYTE_EN
    req_funct3   = 3'b010;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req_ready",  32'(req_ready),     32'd1);
    chk("reset_resp_valid", 32'(resp_valid),    32'd0);
    chk("reset_rd_data",    resp_rd_data,       32'd0);
    chk("reset_tag",        32'(resp_robNum),   32'd0);
    chk("reset_flags",      32'({resp_MemWrite, resp_MemRead, resp_err}), 32'd0);

    // Store then dependent load, latency 2
    issue(32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3, 32'd0, 1'b0);
    chk("t1_no_early_valid", 32'(resp_valid), 32'd0);
    issue(32'h100, 32'd0, 1'b0, 1'b1, 4'd4, 32'hDEADBEEF, 1'b0);
    chk("t1_store_valid_T2", 32'(resp_valid),    32'd1);
    chk("t1_store_tag",      32'(resp_robNum),   32'd3);
    chk("t1_store_mw",       32'(resp_MemWrite), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_load_valid_T3",  32'(resp_valid),    32'd1);
    chk("t1_load_tag",       32'(resp_robNum),   32'd4);
    chk("t1_load_data",      resp_rd_data,       32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: credits run out after QDEPTH accepts
    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid    = 1'b1;
      req_addr     = 32'h100;
      req_MemRead  = 1'b1;
      req_MemWrite = 1'b0;
      req_robNum   = RB'(n_acc);
      if (req_ready) begin
        expect_rsp(32'hDEADBEEF, 1'b0, 1'b1, RB'(n_acc), 1'b0);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("t2_accept_count",   32'(n_acc),       32'd4);
    chk("t2_req_ready_low",  32'(req_ready),   32'd0);
    chk("t2_head_held_tag",  32'(resp_robNum), 32'd0);
    chk("t2_head_held_data", resp_rd_data,     32'hDEADBEEF);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_ready_after_pop", 32'(req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Error cases leave memory untouched
    issue(32'h102, 32'h12345678, 1'b1, 1'b0, 4'd5, 32'd0, 1'b1);
    issue(32'h100, 32'd0, 1'b0, 1'b1, 4'd6, 32'hDEADBEEF, 1'b0);
    issue(32'h1000, 32'd0, 1'b0, 1'b1, 4'd7, 32'd0, 1'b1);
    issue(32'h100, 32'h11111111, 1'b1, 1'b1, 4'd8, 32'd0, 1'b1);
    issue(32'h100, 32'd0, 1'b0, 1'b1, 4'd9, 32'hDEADBEEF, 1'b0);
    issue(32'h200, 32'd0, 1'b0, 1'b0, 4'd10, 32'd0, 1'b0);
    issue(32'hFFC, 32'hCAFEF00D, 1'b1, 1'b0, 4'd11, 32'd0, 1'b0);
    issue(32'hFFC, 32'd0, 1'b0, 1'b1, 4'd12, 32'hCAFEF00D, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Reset discards in-flight responses but keeps memory
    issue(32'h40, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd1, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    issue(32'h40, 32'd0, 1'b0, 1'b1, 4'd13, 32'hA5A5A5A5, 1'b0);
    issue(32'h40, 32'd0, 1'b0, 1'b1, 4'd14, 32'hA5A5A5A5, 1'b0);
    issue(32'h40, 32'd0, 1'b0, 1'b1, 4'd15, 32'hA5A5A5A5, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_valid_after_rst", 32'(resp_valid), 32'd0);
    chk("t5_ready_after_rst", 32'(req_ready),  32'd1);
    resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_stale", 32'(resp_valid), 32'd0);
    issue(32'h40, 32'd0, 1'b0, 1'b1, 4'd2, 32'hA5A5A5A5, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Full credits: pop and request in the same cycle
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(32'h40, 32'd0, 1'b0, 1'b1, RB'(i), 32'hA5A5A5A5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    req_valid    = 1'b1;
    req_addr     = 32'h40;
    req_MemRead  = 1'b1;
    req_MemWrite = 1'b0;
    req_robNum   = 4'd4;
    resp_ready   = 1'b1;
    chk("t6_full_not_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_ready_after_pop", 32'(req_ready), 32'd1);
    if (req_ready) expect_rsp(32'hA5A5A5A5, 1'b0, 1'b1, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_ready_at_qdepth_m1", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
    req_robNum = 4'd5;
    if (req_ready) expect_rsp(32'hA5A5A5A5, 1'b0, 1'b1, 4'd5, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6_full_again", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;

    waited = 0;
    while ((exp_q.size() != 0 || resp_valid) && waited < 60) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    chk("drain_idle",    32'(resp_valid),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
